// File: rtl/sym_enc_pkg.sv
// Shared constants and types for the symbol encoder: the codebook that the
// 4-to-2 decoder inverts, the frame FSM states and the frame length in bits.
package sym_enc_pkg;

  localparam logic [3:0] CODE_SYM00 = 4'b0011;
  localparam logic [3:0] CODE_SYM01 = 4'b0000;
  localparam logic [3:0] CODE_SYM10 = 4'b0001;
  localparam logic [3:0] CODE_SYM11 = 4'b0010;

  // start + four data bits + stop
  localparam int FRAME_BITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/symbol_codebook.sv
// Combinational symbol {Y0,Y1} to codeword {A,B,C,D} lookup.
module symbol_codebook
  import sym_enc_pkg::*;
(
  input  logic [1:0] sym,
  output logic [3:0] code
);

  always_comb begin
    code = CODE_SYM00;
    case (sym)
      2'b00: code = CODE_SYM00;
      2'b01: code = CODE_SYM01;
      2'b10: code = CODE_SYM10;
      2'b11: code = CODE_SYM11;
      default: code = CODE_SYM00;
    endcase
  end

endmodule

// File: rtl/symbol_encoder_tx.sv
// Encodes 2-bit symbols into 4-bit codewords, presents them in parallel and
// sends them as a start/data/stop serial frame on tx.
module symbol_encoder_tx
  import sym_enc_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [3:0] code,
  output logic       code_valid,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // State | meaning
  // IDLE  | line high, waiting for a symbol
  // START | start bit (low)
  // DATA  | codeword bits A..D, MSB first
  // STOP  | stop bit (high), done in its last cycle

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  tx_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     idx, idx_n;
  logic [3:0]     code_n;
  logic           tx_n, busy_n, done_n, code_valid_n;
  logic [3:0]     lookup_code;
  logic           accept;
  logic           last;

  symbol_codebook u_codebook (
    .sym  (sym),
    .code (lookup_code)
  );

  assign sym_ready = (state == IDLE) && !rst;
  assign accept    = sym_valid && sym_ready;
  assign last      = (cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    code_n  = code;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = 2'd0;
          code_n  = lookup_code;
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          idx_n   = 2'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == 2'd3) state_n = STOP;
          else             idx_n   = idx + 2'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = code_n[2'd3 - idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n       = (state_n != IDLE);
    code_valid_n = (state_n != IDLE);
    done_n       = (state_n == STOP) && (cnt_n == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 2'd0;
      code       <= 4'b0000;
      code_valid <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      code       <= code_n;
      code_valid <= code_valid_n;
      tx         <= tx_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_symbol_encoder_tx.sv
// Directed bench for symbol_encoder_tx with BIT_CYCLES = 2 and 1 instances.
module tb_symbol_encoder_tx;

  logic       clk;
  logic       rst;
  logic [1:0] sym;
  logic       v2, v1;
  logic       rdy2, rdy1;
  logic [3:0] code2, code1;
  logic       cv2, cv1, tx2, tx1, busy2, busy1, done2, done1;
  logic [1:0] ref_sym;
  logic [3:0] ref_code;

  int total = 0;
  int bad   = 0;

  symbol_encoder_tx #(.BIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(v2), .sym_ready(rdy2),
    .code(code2), .code_valid(cv2), .tx(tx2), .busy(busy2), .done(done2)
  );

  symbol_encoder_tx #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(v1), .sym_ready(rdy1),
    .code(code1), .code_valid(cv1), .tx(tx1), .busy(busy1), .done(done1)
  );

  symbol_codebook u_ref (.sym(ref_sym), .code(ref_code));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder: Y1 = B xnor D, Y0 = A'B'CD' + A'B'C'D.
  function automatic logic [1:0] decode(input logic [3:0] c);
    logic y0, y1;
    y0 = (!c[3] && !c[2] && c[1] && !c[0]) || (!c[3] && !c[2] && !c[1] && c[0]);
    y1 = !(c[2] ^ c[0]);
    return {y0, y1};
  endfunction

  function automatic logic [3:0] hand_code(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0011;
      2'b01:   return 4'b0000;
      2'b10:   return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // Sends one frame on dut2 starting at the current sample point; returns
  // the codeword recovered from tx (first cycle of each data bit).
  task automatic frame2(input logic [1:0] s, input logic [3:0] exp_code,
                        output logic [3:0] rx);
    logic exp_tx;
    rx = 4'b0000;
    sym = s;
    v2  = 1'b1;
    tick();
    v2  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 2)       exp_tx = 1'b0;
      else if (k <= 10) exp_tx = exp_code[3 - (k - 3) / 2];
      else              exp_tx = 1'b1;
      if (k >= 3 && k <= 9 && (k % 2) == 1) rx[3 - (k - 3) / 2] = tx2;
      total++;
      if (tx2 !== exp_tx) begin
        bad++; $display("FAIL frame_tx k=%0d got=%b want=%b", k, tx2, exp_tx);
      end
      total++;
      if (code2 !== exp_code || cv2 !== 1'b1 || busy2 !== 1'b1 || rdy2 !== 1'b0) begin
        bad++;
        $display("FAIL frame_status k=%0d code=%b cv=%b busy=%b rdy=%b want code=%b 1 1 0",
                 k, code2, cv2, busy2, rdy2, exp_code);
      end
      total++;
      if (done2 !== (k == 12)) begin
        bad++; $display("FAIL frame_done k=%0d got=%b want=%b", k, done2, (k == 12));
      end
      if (k == 1) sym = ~s;
      tick();
    end
    total++;
    if (rdy2 !== 1'b1 || busy2 !== 1'b0 || cv2 !== 1'b0 || done2 !== 1'b0 ||
        tx2 !== 1'b1 || code2 !== exp_code) begin
      bad++;
      $display("FAIL frame_end rdy=%b busy=%b cv=%b done=%b tx=%b code=%b want 1 0 0 0 1 %b",
               rdy2, busy2, cv2, done2, tx2, code2, exp_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v2 = 1'b0; v1 = 1'b0; sym = 2'b00; ref_sym = 2'b00;
    repeat (3) tick();
    total++;
    if (rdy2 !== 1'b0 || rdy1 !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b want=00", rdy2, rdy1);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy2 !== 1'b1 || rdy1 !== 1'b1) begin
      bad++; $display("FAIL release_ready got=%b%b want=11", rdy2, rdy1);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (tx2 !== 1'b1 || rdy2 !== 1'b1 || code2 !== 4'b0000 || cv2 !== 1'b0 ||
          busy2 !== 1'b0 || done2 !== 1'b0 || tx1 !== 1'b1 || rdy1 !== 1'b1 ||
          code1 !== 4'b0000 || cv1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
        bad++;
        $display("FAIL idle_%0d tx=%b rdy=%b code=%b cv=%b busy=%b done=%b want 1 1 0000 0 0 0",
                 i, tx2, rdy2, code2, cv2, busy2, done2);
      end
      tick();
    end
  endtask

  task automatic test_frame_sym10();
    logic [3:0]  rx;
    logic [11:0] seq;
    logic [11:0] want_seq;
    want_seq = 12'b000000001111;
    sym = 2'b10;
    v2  = 1'b1;
    tick();
    v2  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seq[11 - k] = tx2;
      if (k == 11) begin
        total++;
        if (done2 !== 1'b1) begin bad++; $display("FAIL sym10_done got=%b want=1", done2); end
      end
      if (k == 0) begin
        total++;
        if (code2 !== 4'b0001) begin bad++; $display("FAIL sym10_code got=%b want=0001", code2); end
      end
      tick();
    end
    total++;
    if (seq !== want_seq) begin
      bad++; $display("FAIL sym10_seq got=%b want=%b", seq, want_seq);
    end
    total++;
    if (rdy2 !== 1'b1) begin bad++; $display("FAIL sym10_ready got=%b want=1", rdy2); end
    frame2(2'b10, 4'b0001, rx);
  endtask

  task automatic test_sweep();
    logic [3:0] rx;
    for (int i = 0; i < 4; i++) begin
      ref_sym = i[1:0];
      #1;
      total++;
      if (ref_code !== hand_code(i[1:0])) begin
        bad++; $display("FAIL codebook sym=%0d got=%b want=%b", i, ref_code, hand_code(i[1:0]));
      end
      frame2(i[1:0], hand_code(i[1:0]), rx);
      total++;
      if (decode(code2) !== i[1:0]) begin
        bad++; $display("FAIL dec_code sym=%0d got=%b want=%b", i, decode(code2), i[1:0]);
      end
      total++;
      if (decode(rx) !== i[1:0]) begin
        bad++; $display("FAIL dec_tx sym=%0d got=%b want=%b", i, decode(rx), i[1:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    sym = 2'b11;
    v2  = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      if (done2 === 1'b1) dones++;
      if (k == 1) begin
        total++;
        if (code2 !== 4'b0010) begin bad++; $display("FAIL b2b_first got=%b want=0010", code2); end
        sym = 2'b00;
      end
      if (k == 13) begin
        total++;
        if (rdy2 !== 1'b1 || cv2 !== 1'b0) begin
          bad++; $display("FAIL b2b_gap rdy=%b cv=%b want 1 0", rdy2, cv2);
        end
      end
      if (k == 14) begin
        total++;
        if (code2 !== 4'b0011 || cv2 !== 1'b1) begin
          bad++; $display("FAIL b2b_second code=%b cv=%b want 0011 1", code2, cv2);
        end
        v2 = 1'b0;
      end
      tick();
    end
    total++;
    if (dones !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", dones); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] rx;
    int dones = 0;
    sym = 2'b01;
    v2  = 1'b1;
    tick();
    v2  = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || code2 !== 4'b0000 || cv2 !== 1'b0 ||
        done2 !== 1'b0 || rdy2 !== 1'b0) begin
      bad++;
      $display("FAIL abort tx=%b busy=%b code=%b cv=%b done=%b rdy=%b want 1 0 0000 0 0 0",
               tx2, busy2, code2, cv2, done2, rdy2);
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done2 === 1'b1 || tx2 !== 1'b1) dones++;
      tick();
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", dones); end
    // Reset together with a request: reset must win.
    rst = 1'b1; sym = 2'b11; v2 = 1'b1;
    tick();
    rst = 1'b0; v2 = 1'b0;
    total++;
    if (busy2 !== 1'b0 || cv2 !== 1'b0 || tx2 !== 1'b1 || code2 !== 4'b0000) begin
      bad++; $display("FAIL rst_accept busy=%b cv=%b tx=%b code=%b want 0 0 1 0000",
                      busy2, cv2, tx2, code2);
    end
    tick();
    frame2(2'b01, 4'b0000, rx);
  endtask

  task automatic test_bit_cycles_one();
    logic [5:0] seq;
    sym = 2'b00;
    v1  = 1'b1;
    tick();
    v1  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seq[5 - k] = tx1;
      total++;
      if (done1 !== (k == 5)) begin
        bad++; $display("FAIL bc1_done k=%0d got=%b want=%b", k + 1, done1, (k == 5));
      end
      tick();
    end
    total++;
    if (seq !== 6'b000111) begin bad++; $display("FAIL bc1_seq got=%b want=000111", seq); end
    total++;
    if (rdy1 !== 1'b1 || code1 !== 4'b0011 || cv1 !== 1'b0) begin
      bad++; $display("FAIL bc1_end rdy=%b code=%b cv=%b want 1 0011 0", rdy1, code1, cv1);
    end
  endtask

  initial begin
    test_reset();
    test_frame_sym10();
    test_sweep();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_cycles_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbol_encoder_tx.md
# symbol_encoder_tx

Transmit-side counterpart of the 4-to-2-bit code decoder. Accepts 2-bit symbols over a valid/ready handshake and maps each one to the 4-bit codeword {A,B,C,D} that the decoder maps back to the same {Y0,Y1}. The codeword is presented in parallel and also sent as a framed serial stream, so a remote decoder board can be driven over one wire. Sits between symbol-producing logic (switch/FSM sources) and the decoder/7-segment path.

## Interface
- BIT_CYCLES, default 4: clocks per serial bit; legal range 1..255.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sym  in  2  symbol {Y0,Y1} to encode; sampled only on an accept.
- sym_valid  in  1  source has a symbol on sym.
- sym_ready  out  1  block can accept; high only in IDLE and not in reset.
- code  out  4  registered codeword {A,B,C,D}; A = code[3].
- code_valid  out  1  high while code holds the codeword of the frame in progress.
- tx  out  1  serial line; idle high.
- busy  out  1  high from the cycle after accept until the frame ends.
- done  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- Codebook (symbol -> {A,B,C,D}): 00 -> 0011, 01 -> 0000, 10 -> 0001, 11 -> 0010. Each codeword decodes to its own symbol under Y1 = B XNOR D and the decoder's Y0 sum-of-products.
- Accept: sym_valid & sym_ready at a rising edge. sym is captured, code is loaded, and the FSM leaves IDLE. While sym_ready is low, sym_valid is ignored and nothing is queued.
- FSM states, in order:
  - IDLE: tx = 1, sym_ready = 1. Goes to START on accept.
  - START: tx = 0 for BIT_CYCLES cycles.
  - DATA: tx = A, B, C, D in that order, each held for BIT_CYCLES cycles. A 2-bit index advances 0 to 3.
  - STOP: tx = 1 for BIT_CYCLES cycles, then back to IDLE.
- Counters:
  - The bit-cycle counter runs from 0 to BIT_CYCLES-1 and wraps to 0 on each bit boundary.
  - Its width is clog2(BIT_CYCLES), with a minimum of 1.
  - With BIT_CYCLES = 1 every bit lasts exactly one cycle.
- code and code_valid hold from the accept through the end of STOP. code_valid drops when the FSM returns to IDLE. code keeps its last value.
- done is high in the final STOP cycle only.
- tx is a registered output and must be glitch-free.

## Timing
- Reset values: state IDLE, tx 1, code 0000, code_valid 0, busy 0, done 0, counters 0. sym_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- An accept at edge N gives:
  - code, code_valid, busy and tx = 0 (start bit) are all visible from cycle N+1.
  - sym_ready is low from cycle N+1.
  - Start bit: cycles N+1 .. N+BIT_CYCLES.
  - Data bit k (k = 0..3): cycles N+(k+1)*BIT_CYCLES+1 .. N+(k+2)*BIT_CYCLES.
  - Stop bit: cycles N+5*BIT_CYCLES+1 .. N+6*BIT_CYCLES.
  - done is high in cycle N+6*BIT_CYCLES.
  - sym_ready is high again and busy low in cycle N+6*BIT_CYCLES+1.
- A frame is 6*BIT_CYCLES cycles. The minimum accept-to-accept spacing is 6*BIT_CYCLES+1 cycles.
- Reset mid-frame aborts the frame at the next edge: all outputs return to reset values, tx = 1, no done pulse.
- rst and an accept at the same edge: reset wins and no frame starts.
- sym changing while the FSM is not in IDLE has no effect on code or tx.

## Structure
- Package sym_enc_pkg:
  - The four codeword constants.
  - The FSM state enum (IDLE, START, DATA, STOP).
  - Constant FRAME_BITS = 6.
- Sub-module symbol_codebook: purely combinational 2-to-4 lookup built from the package constants. It is instantiated once and reused by the bench as the reference model.
- Top level holds the FSM, the bit-cycle counter, the bit index and the output registers.

## Test plan
- Reset, then idle for 10 cycles -> tx = 1, sym_ready = 1, code = 0000, code_valid = 0, busy = 0, done = 0 throughout.
- BIT_CYCLES = 2, send sym = 10 -> code = 0001 from N+1; tx sequence 0,0,0,0,0,0,0,0,1,1,1,1; done at N+12; sym_ready high at N+13.
- Sweep all four symbols through an instance of the decoder on code and on the deserialized tx -> recovered {Y0,Y1} equals the sent symbol in every case.
- Hold sym_valid high continuously with sym = 11 then 00 -> exactly two frames, first code 0010 then 0011, accepts 13 cycles apart, no symbol lost or duplicated.
- Assert rst at N+5 of a frame -> tx = 1, busy = 0, code = 0000 at N+6, no done pulse, next accept works normally.
- BIT_CYCLES = 1, sym = 00 -> tx 0,0,0,1,1,1 over N+1..N+6; done at N+6.
